// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the fetch queue: lane/slot counts, payload layout
// and a helper that packs one decoded instruction into a storage word.
package fetch_queue_pkg;

  localparam int FQ_NUM_LANES  = 4;
  localparam int FQ_NUM_SLOTS  = 2;
  localparam int FQ_LANE_IDX_W = 2;  // offset of a lane within one enqueue group
  localparam int FQ_ENQ_CNT_W  = 3;  // 0..FQ_NUM_LANES instructions per cycle

  localparam int FQ_FAULT_W = 2;
  localparam int FQ_CLASS_W = 8;

  // Payload field offsets (LSB of each field)
  localparam int FQ_INSTR_LSB       = 0;
  localparam int FQ_PC_LSB          = 32;
  localparam int FQ_FAULT_FETCH_BIT = 64;
  localparam int FQ_FAULT_PAGE_BIT  = 65;
  localparam int FQ_EXEC_BIT        = 66;
  localparam int FQ_LSU_BIT         = 67;
  localparam int FQ_BRANCH_BIT      = 68;
  localparam int FQ_MUL_BIT         = 69;
  localparam int FQ_DIV_BIT         = 70;
  localparam int FQ_CSR_BIT         = 71;
  localparam int FQ_RD_VALID_BIT    = 72;
  localparam int FQ_INVALID_BIT     = 73;
  localparam int FQ_PAYLOAD_W       = 74;

  // Fault group is {page, fetch}; class group is
  // {invalid, rd_valid, csr, div, mul, branch, lsu, exec}, both LSB-first.
  localparam int FQ_FAULT_LSB = FQ_FAULT_FETCH_BIT;
  localparam int FQ_CLASS_LSB = FQ_EXEC_BIT;

  function automatic logic [FQ_PAYLOAD_W-1:0] fq_pack(
    input logic [31:0]           instr,
    input logic [31:0]           pc,
    input logic [FQ_FAULT_W-1:0] fault,
    input logic [FQ_CLASS_W-1:0] cls
  );
    logic [FQ_PAYLOAD_W-1:0] p;
    p = '0;
    p[FQ_INSTR_LSB +: 32]         = instr;
    p[FQ_PC_LSB +: 32]            = pc;
    p[FQ_FAULT_LSB +: FQ_FAULT_W] = fault;
    p[FQ_CLASS_LSB +: FQ_CLASS_W] = cls;
    return p;
  endfunction

endpackage

// File: rtl/fetch_queue_compact.sv
// Combinational 4-lane compactor: each lane's write offset is the number of
// valid lanes below it, so sparse lanes land in consecutive queue slots.
module fetch_queue_compact
  import fetch_queue_pkg::*;
(
  input  logic [FQ_NUM_LANES-1:0]  valid_i,
  output logic [FQ_LANE_IDX_W-1:0] offset_o [FQ_NUM_LANES],
  output logic [FQ_ENQ_CNT_W-1:0]  count_o
);

  // Running prefix count of valid lanes in ascending lane order
  always_comb begin
    logic [FQ_ENQ_CNT_W-1:0] run;
    // NOTE: blocking '=' in combinational logic lets each lane see the running
    // sum already updated by the lanes below it within the same evaluation.
    run = '0;
    for (int n = 0; n < FQ_NUM_LANES; n++) begin
      offset_o[n] = run[FQ_LANE_IDX_W-1:0];
      run         = run + FQ_ENQ_CNT_W'(valid_i[n]);
    end
    count_o = run;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction buffer between the 4-lane decode frontend and the 2-wide issue
// stage. Circular queue with head/tail/count registers, in-order dequeue,
// flush on redirect. Outputs are read from registered storage (no bypass).
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int DEPTH_W = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,

  input  logic          fetch_in0_valid_i,
  input  logic [31:0]   fetch_in0_instr_i,
  input  logic [31:0]   fetch_in0_pc_i,
  input  logic          fetch_in0_fault_fetch_i,
  input  logic          fetch_in0_fault_page_i,
  input  logic          fetch_in0_instr_exec_i,
  input  logic          fetch_in0_instr_lsu_i,
  input  logic          fetch_in0_instr_branch_i,
  input  logic          fetch_in0_instr_mul_i,
  input  logic          fetch_in0_instr_div_i,
  input  logic          fetch_in0_instr_csr_i,
  input  logic          fetch_in0_instr_rd_valid_i,
  input  logic          fetch_in0_instr_invalid_i,
  output logic          fetch_in0_accept_o,

  input  logic          fetch_in1_valid_i,
  input  logic [31:0]   fetch_in1_instr_i,
  input  logic [31:0]   fetch_in1_pc_i,
  input  logic          fetch_in1_fault_fetch_i,
  input  logic          fetch_in1_fault_page_i,
  input  logic          fetch_in1_instr_exec_i,
  input  logic          fetch_in1_instr_lsu_i,
  input  logic          fetch_in1_instr_branch_i,
  input  logic          fetch_in1_instr_mul_i,
  input  logic          fetch_in1_instr_div_i,
  input  logic          fetch_in1_instr_csr_i,
  input  logic          fetch_in1_instr_rd_valid_i,
  input  logic          fetch_in1_instr_invalid_i,
  output logic          fetch_in1_accept_o,

  input  logic          fetch_in2_valid_i,
  input  logic [31:0]   fetch_in2_instr_i,
  input  logic [31:0]   fetch_in2_pc_i,
  input  logic          fetch_in2_fault_fetch_i,
  input  logic          fetch_in2_fault_page_i,
  input  logic          fetch_in2_instr_exec_i,
  input  logic          fetch_in2_instr_lsu_i,
  input  logic          fetch_in2_instr_branch_i,
  input  logic          fetch_in2_instr_mul_i,
  input  logic          fetch_in2_instr_div_i,
  input  logic          fetch_in2_instr_csr_i,
  input  logic          fetch_in2_instr_rd_valid_i,
  input  logic          fetch_in2_instr_invalid_i,
  output logic          fetch_in2_accept_o,

  input  logic          fetch_in3_valid_i,
  input  logic [31:0]   fetch_in3_instr_i,
  input  logic [31:0]   fetch_in3_pc_i,
  input  logic          fetch_in3_fault_fetch_i,
  input  logic          fetch_in3_fault_page_i,
  input  logic          fetch_in3_instr_exec_i,
  input  logic          fetch_in3_instr_lsu_i,
  input  logic          fetch_in3_instr_branch_i,
  input  logic          fetch_in3_instr_mul_i,
  input  logic          fetch_in3_instr_div_i,
  input  logic          fetch_in3_instr_csr_i,
  input  logic          fetch_in3_instr_rd_valid_i,
  input  logic          fetch_in3_instr_invalid_i,
  output logic          fetch_in3_accept_o,

  output logic          issue0_valid_o,
  output logic [31:0]   issue0_instr_o,
  output logic [31:0]   issue0_pc_o,
  output logic          issue0_fault_fetch_o,
  output logic          issue0_fault_page_o,
  output logic          issue0_instr_exec_o,
  output logic          issue0_instr_lsu_o,
  output logic          issue0_instr_branch_o,
  output logic          issue0_instr_mul_o,
  output logic          issue0_instr_div_o,
  output logic          issue0_instr_csr_o,
  output logic          issue0_instr_rd_valid_o,
  output logic          issue0_instr_invalid_o,
  input  logic          issue0_accept_i,

  output logic          issue1_valid_o,
  output logic [31:0]   issue1_instr_o,
  output logic [31:0]   issue1_pc_o,
  output logic          issue1_fault_fetch_o,
  output logic          issue1_fault_page_o,
  output logic          issue1_instr_exec_o,
  output logic          issue1_instr_lsu_o,
  output logic          issue1_instr_branch_o,
  output logic          issue1_instr_mul_o,
  output logic          issue1_instr_div_o,
  output logic          issue1_instr_csr_o,
  output logic          issue1_instr_rd_valid_o,
  output logic          issue1_instr_invalid_o,
  input  logic          issue1_accept_i,

  output logic [DEPTH_W:0] level_o
);

  // Largest occupancy at which a full 4-lane group is still guaranteed to fit
  localparam logic [DEPTH_W:0] ACCEPT_MAX = (DEPTH_W+1)'(DEPTH - FQ_NUM_LANES);

  logic [FQ_NUM_LANES-1:0]  lane_valid;
  logic [FQ_PAYLOAD_W-1:0]  lane_payload [FQ_NUM_LANES];
  logic [FQ_LANE_IDX_W-1:0] lane_offset  [FQ_NUM_LANES];
  logic [FQ_ENQ_CNT_W-1:0]  lane_count;

  logic [DEPTH_W-1:0]       head_q, head_d;
  logic [DEPTH_W-1:0]       tail_q, tail_d;
  logic [DEPTH_W:0]         count_q, count_d;
  logic [FQ_PAYLOAD_W-1:0]  storage_q [DEPTH];
  logic [FQ_PAYLOAD_W-1:0]  storage_d [DEPTH];

  logic                     accept;
  logic [FQ_ENQ_CNT_W-1:0]  enq_n;
  logic                     slot_valid [FQ_NUM_SLOTS];
  logic                     deq0, deq1;
  logic [1:0]               deq_n;
  logic [FQ_PAYLOAD_W-1:0]  slot_payload [FQ_NUM_SLOTS];

  // ---------------------------------------------------------------------------
  // Lane gathering
  // ---------------------------------------------------------------------------
  assign lane_valid = {fetch_in3_valid_i, fetch_in2_valid_i,
                       fetch_in1_valid_i, fetch_in0_valid_i};

  assign lane_payload[0] = fq_pack(fetch_in0_instr_i, fetch_in0_pc_i,
    {fetch_in0_fault_page_i, fetch_in0_fault_fetch_i},
    {fetch_in0_instr_invalid_i, fetch_in0_instr_rd_valid_i, fetch_in0_instr_csr_i,
     fetch_in0_instr_div_i, fetch_in0_instr_mul_i, fetch_in0_instr_branch_i,
     fetch_in0_instr_lsu_i, fetch_in0_instr_exec_i});
  assign lane_payload[1] = fq_pack(fetch_in1_instr_i, fetch_in1_pc_i,
    {fetch_in1_fault_page_i, fetch_in1_fault_fetch_i},
    {fetch_in1_instr_invalid_i, fetch_in1_instr_rd_valid_i, fetch_in1_instr_csr_i,
     fetch_in1_instr_div_i, fetch_in1_instr_mul_i, fetch_in1_instr_branch_i,
     fetch_in1_instr_lsu_i, fetch_in1_instr_exec_i});
  assign lane_payload[2] = fq_pack(fetch_in2_instr_i, fetch_in2_pc_i,
    {fetch_in2_fault_page_i, fetch_in2_fault_fetch_i},
    {fetch_in2_instr_invalid_i, fetch_in2_instr_rd_valid_i, fetch_in2_instr_csr_i,
     fetch_in2_instr_div_i, fetch_in2_instr_mul_i, fetch_in2_instr_branch_i,
     fetch_in2_instr_lsu_i, fetch_in2_instr_exec_i});
  assign lane_payload[3] = fq_pack(fetch_in3_instr_i, fetch_in3_pc_i,
    {fetch_in3_fault_page_i, fetch_in3_fault_fetch_i},
    {fetch_in3_instr_invalid_i, fetch_in3_instr_rd_valid_i, fetch_in3_instr_csr_i,
     fetch_in3_instr_div_i, fetch_in3_instr_mul_i, fetch_in3_instr_branch_i,
     fetch_in3_instr_lsu_i, fetch_in3_instr_exec_i});

  fetch_queue_compact u_compact (
    .valid_i  (lane_valid),
    .offset_o (lane_offset),
    .count_o  (lane_count)
  );

  // ---------------------------------------------------------------------------
  // Handshake: accept from registered count only, in-order dequeue
  // ---------------------------------------------------------------------------
  // Accept, issue-valid and dequeue qualification
  always_comb begin
    // NOTE: every signal gets a value before any condition, so no path leaves
    // one unassigned and no latch is inferred.
    accept        = (count_q <= ACCEPT_MAX) & ~flush_i & ~rst_i;
    enq_n         = accept ? lane_count : '0;
    slot_valid[0] = (count_q >= (DEPTH_W+1)'(1)) & ~flush_i;
    slot_valid[1] = (count_q >= (DEPTH_W+1)'(2)) & ~flush_i;
    deq0          = slot_valid[0] & issue0_accept_i;
    deq1          = deq0 & slot_valid[1] & issue1_accept_i;
    deq_n         = 2'(deq0) + 2'(deq1);
  end

  assign fetch_in0_accept_o = accept;
  assign fetch_in1_accept_o = accept;
  assign fetch_in2_accept_o = accept;
  assign fetch_in3_accept_o = accept;

  // ---------------------------------------------------------------------------
  // Next state: storage writes, pointers and occupancy
  // ---------------------------------------------------------------------------
  // Compacted write of valid lanes starting at tail
  always_comb begin
    storage_d = storage_q;
    if (accept) begin
      for (int n = 0; n < FQ_NUM_LANES; n++) begin
        if (lane_valid[n]) begin
          storage_d[tail_q + DEPTH_W'(lane_offset[n])] = lane_payload[n];
        end
      end
    end
  end

  // Pointer and count update; flush overrides enqueue and dequeue
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + DEPTH_W'(deq_n);
      tail_d  = tail_q + DEPTH_W'(enq_n);
      count_d = count_q + (DEPTH_W+1)'(enq_n) - (DEPTH_W+1)'(deq_n);
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      // NOTE: storage is reset on purpose: payload outputs must read zero
      // after reset, which costs a reset on every storage flop.
      for (int i = 0; i < DEPTH; i++) begin
        storage_q[i] <= '0;
      end
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      storage_q <= storage_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Issue slots: head and head+1, read straight from registered storage
  // ---------------------------------------------------------------------------
  assign slot_payload[0] = storage_q[head_q];
  assign slot_payload[1] = storage_q[head_q + DEPTH_W'(1)];

  assign issue0_valid_o          = slot_valid[0];
  assign issue0_instr_o          = slot_payload[0][FQ_INSTR_LSB +: 32];
  assign issue0_pc_o             = slot_payload[0][FQ_PC_LSB +: 32];
  assign issue0_fault_fetch_o    = slot_payload[0][FQ_FAULT_FETCH_BIT];
  assign issue0_fault_page_o     = slot_payload[0][FQ_FAULT_PAGE_BIT];
  assign issue0_instr_exec_o     = slot_payload[0][FQ_EXEC_BIT];
  assign issue0_instr_lsu_o      = slot_payload[0][FQ_LSU_BIT];
  assign issue0_instr_branch_o   = slot_payload[0][FQ_BRANCH_BIT];
  assign issue0_instr_mul_o      = slot_payload[0][FQ_MUL_BIT];
  assign issue0_instr_div_o      = slot_payload[0][FQ_DIV_BIT];
  assign issue0_instr_csr_o      = slot_payload[0][FQ_CSR_BIT];
  assign issue0_instr_rd_valid_o = slot_payload[0][FQ_RD_VALID_BIT];
  assign issue0_instr_invalid_o  = slot_payload[0][FQ_INVALID_BIT];

  assign issue1_valid_o          = slot_valid[1];
  assign issue1_instr_o          = slot_payload[1][FQ_INSTR_LSB +: 32];
  assign issue1_pc_o             = slot_payload[1][FQ_PC_LSB +: 32];
  assign issue1_fault_fetch_o    = slot_payload[1][FQ_FAULT_FETCH_BIT];
  assign issue1_fault_page_o     = slot_payload[1][FQ_FAULT_PAGE_BIT];
  assign issue1_instr_exec_o     = slot_payload[1][FQ_EXEC_BIT];
  assign issue1_instr_lsu_o      = slot_payload[1][FQ_LSU_BIT];
  assign issue1_instr_branch_o   = slot_payload[1][FQ_BRANCH_BIT];
  assign issue1_instr_mul_o      = slot_payload[1][FQ_MUL_BIT];
  assign issue1_instr_div_o      = slot_payload[1][FQ_DIV_BIT];
  assign issue1_instr_csr_o      = slot_payload[1][FQ_CSR_BIT];
  assign issue1_instr_rd_valid_o = slot_payload[1][FQ_RD_VALID_BIT];
  assign issue1_instr_invalid_o  = slot_payload[1][FQ_INVALID_BIT];

  assign level_o = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, burst/sparse enqueue, fill and wrap,
// in-order dequeue rule, flush priority and asynchronous mid-run reset.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush;
  logic        in_valid [4];
  logic [31:0] in_instr [4];
  logic [31:0] in_pc    [4];
  logic [1:0]  in_fault [4];  // {page, fetch}
  logic [7:0]  in_cls   [4];  // {invalid, rd_valid, csr, div, mul, branch, lsu, exec}
  wire         in_accept [4];

  wire         iss_valid [2];
  wire  [31:0] iss_instr [2];
  wire  [31:0] iss_pc    [2];
  wire  [1:0]  iss_fault [2];
  wire  [7:0]  iss_cls   [2];
  logic        iss_accept [2];
  wire  [4:0]  level;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(16), .DEPTH_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .fetch_in0_valid_i(in_valid[0]), .fetch_in0_instr_i(in_instr[0]), .fetch_in0_pc_i(in_pc[0]),
    .fetch_in0_fault_fetch_i(in_fault[0][0]), .fetch_in0_fault_page_i(in_fault[0][1]),
    .fetch_in0_instr_exec_i(in_cls[0][0]), .fetch_in0_instr_lsu_i(in_cls[0][1]),
    .fetch_in0_instr_branch_i(in_cls[0][2]), .fetch_in0_instr_mul_i(in_cls[0][3]),
    .fetch_in0_instr_div_i(in_cls[0][4]), .fetch_in0_instr_csr_i(in_cls[0][5]),
    .fetch_in0_instr_rd_valid_i(in_cls[0][6]), .fetch_in0_instr_invalid_i(in_cls[0][7]),
    .fetch_in0_accept_o(in_accept[0]),
    .fetch_in1_valid_i(in_valid[1]), .fetch_in1_instr_i(in_instr[1]), .fetch_in1_pc_i(in_pc[1]),
    .fetch_in1_fault_fetch_i(in_fault[1][0]), .fetch_in1_fault_page_i(in_fault[1][1]),
    .fetch_in1_instr_exec_i(in_cls[1][0]), .fetch_in1_instr_lsu_i(in_cls[1][1]),
    .fetch_in1_instr_branch_i(in_cls[1][2]), .fetch_in1_instr_mul_i(in_cls[1][3]),
    .fetch_in1_instr_div_i(in_cls[1][4]), .fetch_in1_instr_csr_i(in_cls[1][5]),
    .fetch_in1_instr_rd_valid_i(in_cls[1][6]), .fetch_in1_instr_invalid_i(in_cls[1][7]),
    .fetch_in1_accept_o(in_accept[1]),
    .fetch_in2_valid_i(in_valid[2]), .fetch_in2_instr_i(in_instr[2]), .fetch_in2_pc_i(in_pc[2]),
    .fetch_in2_fault_fetch_i(in_fault[2][0]), .fetch_in2_fault_page_i(in_fault[2][1]),
    .fetch_in2_instr_exec_i(in_cls[2][0]), .fetch_in2_instr_lsu_i(in_cls[2][1]),
    .fetch_in2_instr_branch_i(in_cls[2][2]), .fetch_in2_instr_mul_i(in_cls[2][3]),
    .fetch_in2_instr_div_i(in_cls[2][4]), .fetch_in2_instr_csr_i(in_cls[2][5]),
    .fetch_in2_instr_rd_valid_i(in_cls[2][6]), .fetch_in2_instr_invalid_i(in_cls[2][7]),
    .fetch_in2_accept_o(in_accept[2]),
    .fetch_in3_valid_i(in_valid[3]), .fetch_in3_instr_i(in_instr[3]), .fetch_in3_pc_i(in_pc[3]),
    .fetch_in3_fault_fetch_i(in_fault[3][0]), .fetch_in3_fault_page_i(in_fault[3][1]),
    .fetch_in3_instr_exec_i(in_cls[3][0]), .fetch_in3_instr_lsu_i(in_cls[3][1]),
    .fetch_in3_instr_branch_i(in_cls[3][2]), .fetch_in3_instr_mul_i(in_cls[3][3]),
    .fetch_in3_instr_div_i(in_cls[3][4]), .fetch_in3_instr_csr_i(in_cls[3][5]),
    .fetch_in3_instr_rd_valid_i(in_cls[3][6]), .fetch_in3_instr_invalid_i(in_cls[3][7]),
    .fetch_in3_accept_o(in_accept[3]),
    .issue0_valid_o(iss_valid[0]), .issue0_instr_o(iss_instr[0]), .issue0_pc_o(iss_pc[0]),
    .issue0_fault_fetch_o(iss_fault[0][0]), .issue0_fault_page_o(iss_fault[0][1]),
    .issue0_instr_exec_o(iss_cls[0][0]), .issue0_instr_lsu_o(iss_cls[0][1]),
    .issue0_instr_branch_o(iss_cls[0][2]), .issue0_instr_mul_o(iss_cls[0][3]),
    .issue0_instr_div_o(iss_cls[0][4]), .issue0_instr_csr_o(iss_cls[0][5]),
    .issue0_instr_rd_valid_o(iss_cls[0][6]), .issue0_instr_invalid_o(iss_cls[0][7]),
    .issue0_accept_i(iss_accept[0]),
    .issue1_valid_o(iss_valid[1]), .issue1_instr_o(iss_instr[1]), .issue1_pc_o(iss_pc[1]),
    .issue1_fault_fetch_o(iss_fault[1][0]), .issue1_fault_page_o(iss_fault[1][1]),
    .issue1_instr_exec_o(iss_cls[1][0]), .issue1_instr_lsu_o(iss_cls[1][1]),
    .issue1_instr_branch_o(iss_cls[1][2]), .issue1_instr_mul_o(iss_cls[1][3]),
    .issue1_instr_div_o(iss_cls[1][4]), .issue1_instr_csr_o(iss_cls[1][5]),
    .issue1_instr_rd_valid_o(iss_cls[1][6]), .issue1_instr_invalid_o(iss_cls[1][7]),
    .issue1_accept_i(iss_accept[1]),
    .level_o(level)
  );

  // Advance one clock; sample 1 ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Lane payload derived from the PC: instr = C0DE0000|pc, fault = lane, cls = pc[9:2]
  task automatic set_lane(input int n, input logic [31:0] pc);
    in_valid[n] = 1'b1;
    in_pc[n]    = pc;
    in_instr[n] = 32'hC0DE_0000 | pc;
    in_fault[n] = 2'(n);
    in_cls[n]   = pc[9:2];
  endtask

  task automatic clear_lanes();
    for (int n = 0; n < 4; n++) in_valid[n] = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL rst_level: got %0d want 0", level); end
    checks++; if (iss_valid[0] !== 1'b0 || iss_valid[1] !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b%b want 00", iss_valid[1], iss_valid[0]); end
    checks++; if (in_accept[0] !== 1'b0) begin errors++; $display("FAIL rst_accept: got %b want 0", in_accept[0]); end
    checks++; if (iss_pc[0] !== 32'h0 || iss_instr[1] !== 32'h0) begin errors++; $display("FAIL rst_payload: got pc0=%h instr1=%h want 0", iss_pc[0], iss_instr[1]); end
    rst = 1'b0;
    step();
    for (int n = 0; n < 4; n++) begin
      checks++; if (in_accept[n] !== 1'b1) begin errors++; $display("FAIL idle_accept%0d: got %b want 1", n, in_accept[n]); end
    end
    checks++; if (level !== 5'd0 || iss_valid[0] !== 1'b0 || iss_valid[1] !== 1'b0) begin errors++; $display("FAIL idle_state: got level=%0d v=%b%b want 0/00", level, iss_valid[1], iss_valid[0]); end
  endtask

  task automatic test_burst();
    for (int n = 0; n < 4; n++) set_lane(n, 32'h100 + 32'(4*n));
    #1;
    checks++; if (iss_valid[0] !== 1'b0) begin errors++; $display("FAIL burst_no_bypass: got %b want 0", iss_valid[0]); end
    step();
    clear_lanes();
    checks++; if (iss_pc[0] !== 32'h100) begin errors++; $display("FAIL burst_pc0: got %h want 00000100", iss_pc[0]); end
    checks++; if (iss_pc[1] !== 32'h104) begin errors++; $display("FAIL burst_pc1: got %h want 00000104", iss_pc[1]); end
    checks++; if (level !== 5'd4) begin errors++; $display("FAIL burst_level: got %0d want 4", level); end
    checks++; if (iss_valid[0] !== 1'b1 || iss_valid[1] !== 1'b1) begin errors++; $display("FAIL burst_valid: got %b%b want 11", iss_valid[1], iss_valid[0]); end
    checks++; if (iss_instr[0] !== 32'hC0DE_0100) begin errors++; $display("FAIL burst_instr0: got %h want c0de0100", iss_instr[0]); end
    checks++; if (iss_cls[1] !== 8'h41 || iss_fault[1] !== 2'd1) begin errors++; $display("FAIL burst_flags1: got cls=%h fault=%0d want 41/1", iss_cls[1], iss_fault[1]); end
    iss_accept[0] = 1'b1; iss_accept[1] = 1'b1;
    step();
    checks++; if (level !== 5'd2 || iss_pc[0] !== 32'h108 || iss_pc[1] !== 32'h10C) begin errors++; $display("FAIL burst_deq2: got level=%0d pc0=%h pc1=%h want 2/108/10c", level, iss_pc[0], iss_pc[1]); end
    step();
    iss_accept[0] = 1'b0; iss_accept[1] = 1'b0;
    checks++; if (level !== 5'd0 || iss_valid[0] !== 1'b0) begin errors++; $display("FAIL burst_drain: got level=%0d v0=%b want 0/0", level, iss_valid[0]); end
  endtask

  task automatic test_sparse();
    set_lane(1, 32'h204);
    set_lane(3, 32'h20C);
    step();
    clear_lanes();
    checks++; if (iss_pc[0] !== 32'h204 || iss_pc[1] !== 32'h20C) begin errors++; $display("FAIL sparse_pc: got %h %h want 204 20c", iss_pc[0], iss_pc[1]); end
    checks++; if (level !== 5'd2) begin errors++; $display("FAIL sparse_level: got %0d want 2", level); end
    checks++; if (iss_cls[0] !== 8'h81 || iss_fault[0] !== 2'd1 || iss_fault[1] !== 2'd3) begin errors++; $display("FAIL sparse_flags: got cls0=%h f0=%0d f1=%0d want 81/1/3", iss_cls[0], iss_fault[0], iss_fault[1]); end
    iss_accept[0] = 1'b1; iss_accept[1] = 1'b1;
    step();
    iss_accept[0] = 1'b0; iss_accept[1] = 1'b0;
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL sparse_drain: got %0d want 0", level); end
  endtask

  // Head/tail sit at 6 here, so 13 entries occupy indices 6..15,0..2
  task automatic test_fill_wrap();
    int k = 0;
    for (int b = 0; b < 3; b++) begin
      for (int n = 0; n < 4; n++) begin
        set_lane(n, 32'h300 + 32'(4*k));
        k++;
      end
      step();
      clear_lanes();
    end
    checks++; if (level !== 5'd12 || in_accept[0] !== 1'b1) begin errors++; $display("FAIL fill12: got level=%0d acc=%b want 12/1", level, in_accept[0]); end
    set_lane(0, 32'h330);
    step();
    clear_lanes();
    checks++; if (level !== 5'd13) begin errors++; $display("FAIL fill13_level: got %0d want 13", level); end
    for (int n = 0; n < 4; n++) begin
      checks++; if (in_accept[n] !== 1'b0) begin errors++; $display("FAIL full_accept%0d: got %b want 0", n, in_accept[n]); end
    end
    for (int n = 0; n < 4; n++) set_lane(n, 32'h900 + 32'(4*n));
    step();
    clear_lanes();
    checks++; if (level !== 5'd13) begin errors++; $display("FAIL full_hold: got %0d want 13", level); end
    iss_accept[0] = 1'b1; iss_accept[1] = 1'b1;
    step();
    iss_accept[0] = 1'b0; iss_accept[1] = 1'b0;
    checks++; if (level !== 5'd11 || in_accept[0] !== 1'b1) begin errors++; $display("FAIL deq_to11: got level=%0d acc=%b want 11/1", level, in_accept[0]); end
    for (int j = 2; j < 13; j++) begin
      checks++; if (iss_pc[0] !== 32'h300 + 32'(4*j)) begin errors++; $display("FAIL wrap_order%0d: got %h want %h", j, iss_pc[0], 32'h300 + 32'(4*j)); end
      iss_accept[0] = 1'b1;
      step();
      iss_accept[0] = 1'b0;
    end
    checks++; if (level !== 5'd0 || iss_valid[0] !== 1'b0) begin errors++; $display("FAIL wrap_empty: got level=%0d v0=%b want 0/0", level, iss_valid[0]); end
  endtask

  task automatic test_accept1_only();
    for (int n = 0; n < 3; n++) set_lane(n, 32'h500 + 32'(4*n));
    step();
    clear_lanes();
    checks++; if (level !== 5'd3) begin errors++; $display("FAIL a1_level: got %0d want 3", level); end
    iss_accept[1] = 1'b1;
    step();
    iss_accept[1] = 1'b0;
    checks++; if (level !== 5'd3 || iss_pc[0] !== 32'h500) begin errors++; $display("FAIL a1_ignored: got level=%0d pc0=%h want 3/500", level, iss_pc[0]); end
    iss_accept[0] = 1'b1;
    step();
    iss_accept[0] = 1'b0;
    checks++; if (level !== 5'd2 || iss_pc[0] !== 32'h504) begin errors++; $display("FAIL a0_only: got level=%0d pc0=%h want 2/504", level, iss_pc[0]); end
    iss_accept[0] = 1'b1; iss_accept[1] = 1'b1;
    step();
    iss_accept[0] = 1'b0; iss_accept[1] = 1'b0;
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL a1_drain: got %0d want 0", level); end
  endtask

  task automatic test_flush();
    for (int b = 0; b < 2; b++) begin
      for (int n = 0; n < 4; n++) set_lane(n, 32'h600 + 32'(16*b + 4*n));
      step();
      clear_lanes();
    end
    checks++; if (level !== 5'd8) begin errors++; $display("FAIL flush_pre: got %0d want 8", level); end
    flush = 1'b1;
    for (int n = 0; n < 4; n++) set_lane(n, 32'h700 + 32'(4*n));
    iss_accept[0] = 1'b1; iss_accept[1] = 1'b1;
    #1;
    checks++; if (in_accept[0] !== 1'b0 || iss_valid[0] !== 1'b0 || iss_valid[1] !== 1'b0) begin errors++; $display("FAIL flush_comb: got acc=%b v=%b%b want 0/00", in_accept[0], iss_valid[1], iss_valid[0]); end
    step();
    flush = 1'b0;
    clear_lanes();
    iss_accept[0] = 1'b0; iss_accept[1] = 1'b0;
    checks++; if (level !== 5'd0 || iss_valid[0] !== 1'b0 || iss_valid[1] !== 1'b0) begin errors++; $display("FAIL flush_post: got level=%0d v=%b%b want 0/00", level, iss_valid[1], iss_valid[0]); end
    set_lane(0, 32'h400);
    step();
    clear_lanes();
    checks++; if (iss_valid[0] !== 1'b1 || iss_pc[0] !== 32'h400) begin errors++; $display("FAIL flush_reenq: got v0=%b pc0=%h want 1/400", iss_valid[0], iss_pc[0]); end
    checks++; if (iss_valid[1] !== 1'b0 || level !== 5'd1) begin errors++; $display("FAIL flush_reenq_level: got v1=%b level=%0d want 0/1", iss_valid[1], level); end
  endtask

  task automatic test_mid_reset();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (level !== 5'd0 || iss_valid[0] !== 1'b0) begin errors++; $display("FAIL async_rst: got level=%0d v0=%b want 0/0", level, iss_valid[0]); end
    checks++; if (iss_pc[0] !== 32'h0) begin errors++; $display("FAIL async_rst_storage: got pc0=%h want 0", iss_pc[0]); end
    #1;
    rst = 1'b0;
    step();
    checks++; if (level !== 5'd0 || in_accept[2] !== 1'b1) begin errors++; $display("FAIL post_rst: got level=%0d acc=%b want 0/1", level, in_accept[2]); end
  endtask

  initial begin
    flush = 1'b0;
    iss_accept[0] = 1'b0;
    iss_accept[1] = 1'b0;
    for (int n = 0; n < 4; n++) begin
      in_valid[n] = 1'b0;
      in_instr[n] = '0;
      in_pc[n]    = '0;
      in_fault[n] = '0;
      in_cls[n]   = '0;
    end
    test_reset();
    test_burst();
    test_sparse();
    test_fill_wrap();
    test_accept1_only();
    test_flush();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
